// File: rtl/add_norm_arbiter_if.sv
// Bundle of requester-side and result-side signals for add_norm_arbiter.
// The arbiter connects through the slave modport; requesters and the downstream stage use master.
interface add_norm_arbiter_if #(
  parameter int N_REQ                = 4,
  parameter int TE_BITS              = 12,
  parameter int MANT_ADD_RESULT_SIZE = 30,
  parameter int ID_BITS              = $clog2(N_REQ)
);
  logic [N_REQ-1:0]                      req_valid_i;
  logic [N_REQ-1:0]                      req_ready_o;
  logic [N_REQ*MANT_ADD_RESULT_SIZE-1:0] req_mant_i;
  logic [N_REQ*TE_BITS-1:0]              req_te_diff_i;
  logic                                  res_valid_o;
  logic                                  res_ready_i;
  logic [MANT_ADD_RESULT_SIZE-1:0]       res_mant_o;
  logic [TE_BITS-1:0]                    res_te_diff_o;
  logic                                  res_frac_truncated_o;
  logic [ID_BITS-1:0]                    res_id_o;
  logic                                  busy_o;
  logic                                  state_dbg;

  modport slave (
    input  req_valid_i, req_mant_i, req_te_diff_i, res_ready_i,
    output req_ready_o, res_valid_o, res_mant_o, res_te_diff_o,
           res_frac_truncated_o, res_id_o, busy_o, state_dbg
  );

  modport master (
    output req_valid_i, req_mant_i, req_te_diff_i, res_ready_i,
    input  req_ready_o, res_valid_o, res_mant_o, res_te_diff_o,
           res_frac_truncated_o, res_id_o, busy_o, state_dbg
  );
endinterface

// File: rtl/add_norm_arbiter.sv
// Round-robin arbiter feeding one shared carry-normalisation stage with a one-entry result register.
// Handshake: a beat moves on valid & ready; senders hold valid and data stable until accepted.
module add_norm_arbiter #(
  parameter int N_REQ                = 4,
  parameter int TE_BITS              = 12,
  parameter int MANT_ADD_RESULT_SIZE = 30,
  localparam int ID_BITS             = $clog2(N_REQ)
) (
  input logic clk_i,
  input logic rst_i,
  add_norm_arbiter_if.slave bus
);
  localparam int MW = MANT_ADD_RESULT_SIZE;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [ID_BITS-1:0]  rr_q;
  logic [ID_BITS-1:0]  gnt_idx;
  logic                found;
  logic                can_accept;
  logic                grant;
  logic [MW-1:0]       mant_sel;
  logic [TE_BITS-1:0]  te_sel;
  logic                carry;

  // Rotating priority search starting at the rr pointer.
  always_comb begin
    int idx;
    found   = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(rr_q) + i) % N_REQ;
      if (!found && bus.req_valid_i[idx]) begin
        found   = 1'b1;
        gnt_idx = ID_BITS'(idx);
      end
    end
  end

  // Gating with rst_i keeps every ready low while reset is held.
  assign can_accept = (state_q == EMPTY) || bus.res_ready_i;
  assign grant      = found && can_accept && rst_i;

  always_comb begin
    bus.req_ready_o = '0;
    if (grant) bus.req_ready_o[gnt_idx] = 1'b1;
  end

  assign mant_sel = bus.req_mant_i[int'(gnt_idx)*MW +: MW];
  assign te_sel   = bus.req_te_diff_i[int'(gnt_idx)*TE_BITS +: TE_BITS];
  assign carry    = mant_sel[MW-1];

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (grant) state_d = FULL;
      FULL:    if (bus.res_ready_i && !grant) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q                  <= EMPTY;
      rr_q                     <= '0;
      bus.res_mant_o           <= '0;
      bus.res_te_diff_o        <= '0;
      bus.res_frac_truncated_o <= 1'b0;
      bus.res_id_o             <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        rr_q                     <= (gnt_idx == ID_BITS'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
        bus.res_mant_o           <= carry ? (mant_sel >> 1) : mant_sel;
        bus.res_te_diff_o        <= carry ? te_sel + 1'b1 : te_sel;
        bus.res_frac_truncated_o <= carry & mant_sel[0];
        bus.res_id_o             <= gnt_idx;
      end
    end
  end

  assign bus.res_valid_o = (state_q == FULL);
  assign bus.busy_o      = bus.res_valid_o || (|bus.req_valid_i);
  assign bus.state_dbg   = state_q;
endmodule

// File: tb/tb_add_norm_arbiter.sv
// Directed bench for add_norm_arbiter: expected results are queued at issue time
// and a negedge monitor pops and compares them on every result transfer.
module tb_add_norm_arbiter;
  localparam int N  = 4;
  localparam int TB = 4;
  localparam int MW = 8;
  localparam int IB = 2;
  localparam int W  = MW + TB + 1 + IB;

  logic clk;
  logic rst_i;

  add_norm_arbiter_if #(.N_REQ(N), .TE_BITS(TB), .MANT_ADD_RESULT_SIZE(MW)) bus ();

  add_norm_arbiter #(.N_REQ(N), .TE_BITS(TB), .MANT_ADD_RESULT_SIZE(MW)) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [W-1:0] pack(input logic [MW-1:0] m, input logic [TB-1:0] t,
                                        input logic tr, input logic [IB-1:0] id);
    return {m, t, tr, id};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [MW-1:0] m, input logic [TB-1:0] t);
    bus.req_mant_i[k*MW +: MW]    = m;
    bus.req_te_diff_i[k*TB +: TB] = t;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_i && bus.res_valid_o && bus.res_ready_i) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_result: got 0x%0h expected none", {bus.res_mant_o,
                 bus.res_te_diff_o, bus.res_frac_truncated_o, bus.res_id_o});
      end else begin
        check("result", 32'({bus.res_mant_o, bus.res_te_diff_o,
                             bus.res_frac_truncated_o, bus.res_id_o}), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    rst_i           = 1'b0;
    bus.req_valid_i = 4'b1111;
    bus.res_ready_i = 1'b1;
    bus.req_mant_i  = '1;
    bus.req_te_diff_i = '1;

    // reset holds everything low even with all requests valid
    #3;
    @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready_o), 32'h0);
    check("rst_res_valid", 32'(bus.res_valid_o), 32'h0);
    check("rst_res_mant",  32'(bus.res_mant_o), 32'h0);
    check("rst_res_te",    32'(bus.res_te_diff_o), 32'h0);
    check("rst_res_trunc", 32'(bus.res_frac_truncated_o), 32'h0);
    check("rst_res_id",    32'(bus.res_id_o), 32'h0);
    bus.req_valid_i = '0;
    step();
    rst_i = 1'b1;
    step();

    // carry normalisation on requester 2
    set_req(2, 8'b1000_0011, 4'd5);
    bus.req_valid_i = 4'b0100;
    exp_q.push_back(pack(8'b0100_0001, 4'd6, 1'b1, 2'd2));
    #1;
    check("grant_req2", 32'(bus.req_ready_o), 32'h4);
    step();
    bus.req_valid_i = '0;
    step();

    // no carry, then carry with te wrap
    set_req(3, 8'b0110_0001, 4'd15);
    bus.req_valid_i = 4'b1000;
    exp_q.push_back(pack(8'b0110_0001, 4'd15, 1'b0, 2'd3));
    step();
    set_req(3, 8'b1000_0000, 4'd15);
    exp_q.push_back(pack(8'b0100_0000, 4'd0, 1'b0, 2'd3));
    step();
    bus.req_valid_i = '0;
    step();

    // full rotation with all four requesting
    set_req(0, 8'h81, 4'd3);
    set_req(1, 8'h22, 4'd7);
    set_req(2, 8'hFE, 4'd15);
    set_req(3, 8'h10, 4'd0);
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(pack(8'h40, 4'd4, 1'b1, 2'd0));
      exp_q.push_back(pack(8'h22, 4'd7, 1'b0, 2'd1));
      exp_q.push_back(pack(8'h7F, 4'd0, 1'b0, 2'd2));
      exp_q.push_back(pack(8'h10, 4'd0, 1'b0, 2'd3));
    end
    bus.req_valid_i = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      step();
      check("rot_no_bubble", 32'(bus.res_valid_o), 32'h1);
    end
    bus.req_valid_i = '0;
    step();

    // only 1 and 3 valid: alternate
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(pack(8'h22, 4'd7, 1'b0, 2'd1));
      exp_q.push_back(pack(8'h10, 4'd0, 1'b0, 2'd3));
    end
    bus.req_valid_i = 4'b1010;
    repeat (4) step();
    bus.req_valid_i = '0;
    step();

    // backpressure: hold result for three cycles
    bus.res_ready_i = 1'b0;
    bus.req_valid_i = 4'b0011;
    exp_q.push_back(pack(8'h40, 4'd4, 1'b1, 2'd0));
    step();
    bus.req_valid_i = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      check("bp_req_ready", 32'(bus.req_ready_o), 32'h0);
      check("bp_res_valid", 32'(bus.res_valid_o), 32'h1);
      check("bp_res_data", 32'({bus.res_mant_o, bus.res_te_diff_o,
                                bus.res_frac_truncated_o, bus.res_id_o}),
            32'(pack(8'h40, 4'd4, 1'b1, 2'd0)));
      step();
    end
    bus.res_ready_i = 1'b1;
    exp_q.push_back(pack(8'h22, 4'd7, 1'b0, 2'd1));
    #1;
    check("bp_release_ready", 32'(bus.req_ready_o), 32'h2);
    step();
    bus.req_valid_i = '0;
    check("bp_back_to_back_id", 32'(bus.res_id_o), 32'h1);
    check("bp_back_to_back_valid", 32'(bus.res_valid_o), 32'h1);
    step();

    // async reset while FULL discards the held result and the rr pointer
    bus.res_ready_i = 1'b0;
    set_req(2, 8'h10, 4'd0);
    bus.req_valid_i = 4'b0100;
    step();
    bus.req_valid_i = '0;
    #2;
    rst_i = 1'b0;
    #1;
    check("arst_res_valid", 32'(bus.res_valid_o), 32'h0);
    check("arst_state", 32'(bus.state_dbg), 32'h0);
    bus.req_valid_i = 4'b1010;
    bus.res_ready_i = 1'b1;
    #1;
    check("arst_req_ready", 32'(bus.req_ready_o), 32'h0);
    step();
    rst_i = 1'b1;
    #1;
    check("post_rst_grant", 32'(bus.req_ready_o), 32'h2);
    exp_q.push_back(pack(8'h22, 4'd7, 1'b0, 2'd1));
    step();
    bus.req_valid_i = '0;
    step();

    // bounded drain of the scoreboard
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    check("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
